mem_burst_master: RTL and testbench
===================================

MEM_BURST_MASTER -- requirements
Module: mem_burst_master

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-003 SHALL have port cmd_valid, input, 1 bit: a burst command is presented.
REQ-004 SHALL have port cmd_ready, output, 1 bit: the block can accept a command.
REQ-005 SHALL have port cmd_write, input, 1 bit: 1 = write burst, 0 = read burst.
REQ-006 SHALL have port cmd_addr, input, 32 bits: first word address.
REQ-007 SHALL have port cmd_len, input, 4 bits: burst length minus one (1..16 words).
REQ-008 SHALL have port wr_valid, input, 1 bit: write data word presented.
REQ-009 SHALL have port wr_ready, output, 1 bit: write data word accepted this cycle.
REQ-010 SHALL have port wr_data, input, 32 bits: write data word.
REQ-011 SHALL have port rd_valid, output, 1 bit: read data word available.
REQ-012 SHALL have port rd_ready, input, 1 bit: consumer takes the read word.
REQ-013 SHALL have port rd_data, output, 32 bits: read data word.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse at burst completion.
REQ-015 SHALL have port mem_read, output, 1 bit: read strobe to word memory.
REQ-016 SHALL have port mem_write, output, 1 bit: write strobe to word memory.
REQ-017 SHALL have port mem_addrs, output, 32 bits: word address to memory.
REQ-018 SHALL have port mem_data_in, output, 32 bits: write data to memory.
REQ-019 SHALL have port mem_data_out, input, 32 bits: read data from memory; the memory samples strobes on the falling edge and holds mem_data_out.

Function
REQ-020 SHALL drive all outputs from registers, except cmd_ready, wr_ready and rd_valid, which are decoded from state only.
REQ-021 SHALL implement states IDLE, RD_ISSUE, RD_RESP, WR_DATA, WR_ISSUE and DONE.
REQ-022 IDLE: cmd_ready=1.
- On cmd_valid, latch addr=cmd_addr, count=cmd_len and dir=cmd_write.
- Then go to WR_DATA if dir=1, otherwise RD_ISSUE.
REQ-023 RD_ISSUE: mem_read=1 and mem_addrs=addr for exactly one cycle.
- At the next edge, capture rd_data<=mem_data_out and go to RD_RESP.
REQ-024 RD_RESP: rd_valid=1 and rd_data held stable.
- On rd_ready with count=0, go to DONE.
- On rd_ready with count≠0, set addr+=1 and count-=1, then go to RD_ISSUE.
- Without rd_ready, stay.
REQ-025 WR_DATA: wr_ready=1.
- On wr_valid, latch mem_data_in<=wr_data and go to WR_ISSUE.
- Without wr_valid, stay.
REQ-026 WR_ISSUE: mem_write=1, mem_addrs=addr and mem_data_in stable for exactly one cycle.
- Then go to DONE if count=0.
- Otherwise set addr+=1 and count-=1, then go to WR_DATA.
REQ-027 DONE: done=1 for one cycle, then go to IDLE; cmd_ready=0 in DONE.
REQ-028 SHALL never assert mem_read and mem_write in the same cycle; each strobe lasts exactly one cycle per word.
REQ-029 Throughput: read burst = 2 cycles/word minimum, write burst = 2 cycles/word minimum, plus 1 DONE cycle.
REQ-030 Address increment SHALL be modulo 2^32 (0xFFFFFFFF+1 = 0x00000000).
REQ-031 cmd_len=0 SHALL transfer exactly one word; cmd_len=15 SHALL transfer 16 words.
REQ-032 Command inputs outside IDLE SHALL be ignored; wr_valid outside WR_DATA SHALL be ignored; rd_ready outside RD_RESP SHALL be ignored.
REQ-033 Memory address/data outputs SHALL hold their last values when strobes are low.

Reset
REQ-034 reset=1 at a rising edge SHALL force IDLE and clear all registered outputs to 0: mem_read, mem_write, mem_addrs, mem_data_in, rd_data, done, plus internal addr/count/dir.
REQ-035 reset SHALL take priority over all transitions; a burst in progress SHALL be abandoned, with no further strobes in the cycle after reset and no done pulse.
REQ-036 In the first cycle after reset deasserts, cmd_ready SHALL be 1.

Verification
REQ-037 Single read: memory[0x10]=0xDEADBEEF, cmd read addr=0x10 len=0, rd_ready=1 -> one mem_read cycle at 0x10, rd_valid with rd_data=0xDEADBEEF next cycle, then done pulse.
REQ-038 Write burst: cmd write addr=0x20 len=3, wr_data 0xA0..0xA3 -> four one-cycle mem_write pulses at 0x20..0x23, memory holds 0xA0..0xA3, one done pulse.
REQ-039 Backpressure: read len=1 at 0x30 with rd_ready low for 5 cycles -> rd_valid/rd_data stable, no second mem_read until rd_ready high.
REQ-040 Wrap: write addr=0xFFFFFFFF len=1 -> strobes at 0xFFFFFFFF then 0x00000000.
REQ-041 Reset mid-burst: reset during WR_DATA of word 2 of len=3 -> next cycle mem_write=0, cmd_ready=1, no done pulse; memory words beyond word 1 untouched.
REQ-042 Exclusivity: randomized mixed bursts -> mem_read&mem_write never both 1, and done count equals accepted command count.

Source files
------------

// File: rtl/mem_burst_master.sv
// rtl/mem_burst_master.sv - burst read/write master driving a word memory one strobe per word
module mem_burst_master (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [3:0]  cmd_len,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] rd_data,
  output logic        done,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addrs,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ISSUE, S_RD_RESP, S_WR_DATA, S_WR_ISSUE, S_DONE
  } state_t;

  state_t      state;
  logic [31:0] addr;
  logic [3:0]  count;
  logic        dir;
  logic [31:0] addr_inc;
  logic        word_done;

  assign addr_inc  = addr + 32'd1;
  assign cmd_ready = (state == S_IDLE);
  assign wr_ready  = (state == S_WR_DATA);
  assign rd_valid  = (state == S_RD_RESP);
  assign word_done = (state == S_WR_ISSUE) || ((state == S_RD_RESP) && rd_ready);

  // Strobes and done are single-cycle: cleared every cycle unless re-armed below.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      addr        <= 32'd0;
      count       <= 4'd0;
      dir         <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addrs   <= 32'd0;
      mem_data_in <= 32'd0;
      rd_data     <= 32'd0;
      done        <= 1'b0;
    end else begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr  <= cmd_addr;
            count <= cmd_len;
            dir   <= cmd_write;
            if (cmd_write) begin
              state <= S_WR_DATA;
            end else begin
              state     <= S_RD_ISSUE;
              mem_read  <= 1'b1;
              mem_addrs <= cmd_addr;
            end
          end
        end
        S_RD_ISSUE: begin
          rd_data <= mem_data_out;
          state   <= S_RD_RESP;
        end
        S_WR_DATA: begin
          if (wr_valid) begin
            mem_data_in <= wr_data;
            mem_write   <= 1'b1;
            mem_addrs   <= addr;
            state       <= S_WR_ISSUE;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_RD_RESP, S_WR_ISSUE: ;
        default: state <= S_IDLE;
      endcase

      // Shared end-of-word step for both directions; dir picks the next word's entry state.
      if (word_done) begin
        if (count == 4'd0) begin
          state <= S_DONE;
          done  <= 1'b1;
        end else begin
          addr  <= addr_inc;
          count <= count - 4'd1;
          if (dir) begin
            state <= S_WR_DATA;
          end else begin
            state     <= S_RD_ISSUE;
            mem_read  <= 1'b1;
            mem_addrs <= addr_inc;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_burst_master.sv
// tb/tb_mem_burst_master.sv - transaction-level model and directed bursts for mem_burst_master
module tb_mem_burst_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = 32'd0;
  logic [3:0]  cmd_len = 4'd0;
  logic        wr_valid = 1'b0, wr_ready;
  logic [31:0] wr_data = 32'd0;
  logic        rd_valid, rd_ready = 1'b0;
  logic [31:0] rd_data;
  logic        done, mem_read, mem_write;
  logic [31:0] mem_addrs, mem_data_in;
  logic [31:0] mem_data_out = 32'd0;

  always #5 clk = ~clk;

  mem_burst_master dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addrs(mem_addrs), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Word memory: samples strobes on the falling edge and holds its read output.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'd0;
  endfunction

  // Transaction model: an accepted command expands into its list of {write, address} strobes.
  logic [32:0] exp_strobe[$];
  logic [31:0] exp_wdata[$];
  logic [31:0] exp_rd[$];
  logic [31:0] strobe_log[$];
  logic [32:0] exp_e;
  int          rd_left = 0;
  int          cmd_count = 0;
  int          done_count = 0;
  bit          exp_done = 0, nxt_done;
  bit          prev_rd_strobe = 0, prev_wr_strobe = 0, prev_wr_hs = 0, prev_rd_wait = 0;
  logic [31:0] prev_rd_data = 32'd0;
  logic [31:0] last_rd = 32'd0;

  always @(negedge clk) begin
    if (reset) begin
      exp_strobe.delete();
      exp_wdata.delete();
      exp_rd.delete();
      rd_left = 0;
      exp_done = 0;
      prev_rd_strobe = 0;
      prev_wr_strobe = 0;
      prev_wr_hs = 0;
      prev_rd_wait = 0;
      cmd_count = done_count;
    end else begin
      nxt_done = 0;
      chk("exclusive_strobes", 32'(mem_read & mem_write), 32'd0);
      chk("done_pulse", 32'(done), 32'(exp_done));
      if (done) done_count++;
      if (prev_rd_strobe) begin
        chk("rd_valid_after_read", 32'(rd_valid), 32'd1);
        chk("mem_read_one_cycle", 32'(mem_read), 32'd0);
        if (exp_rd.size() > 0) chk("rd_data_captured", rd_data, exp_rd[0]);
        else fail_now("rd_data_no_expectation");
      end
      if (prev_wr_strobe) chk("mem_write_one_cycle", 32'(mem_write), 32'd0);
      if (prev_wr_hs) chk("mem_write_after_wr", 32'(mem_write), 32'd1);
      if (prev_rd_wait && rd_valid) chk("rd_data_stable", rd_data, prev_rd_data);
      if (rd_valid) chk("no_read_while_waiting", 32'(mem_read), 32'd0);
      if (mem_read || mem_write) begin
        strobe_log.push_back(mem_addrs);
        if (exp_strobe.size() == 0) begin
          fail_now("unexpected_strobe");
        end else begin
          exp_e = exp_strobe.pop_front();
          chk("strobe_addr", mem_addrs, exp_e[31:0]);
          chk("strobe_dir", 32'(mem_write), 32'(exp_e[32]));
          if (mem_write) begin
            if (exp_wdata.size() > 0) chk("mem_data_in", mem_data_in, exp_wdata.pop_front());
            else fail_now("write_without_data");
            if (exp_strobe.size() == 0) nxt_done = 1;
          end else begin
            exp_rd.push_back(mem_rd(mem_addrs));
          end
        end
      end
      if (rd_valid && rd_ready) begin
        last_rd = rd_data;
        if (exp_rd.size() > 0) chk("rd_handshake_data", rd_data, exp_rd.pop_front());
        else fail_now("rd_handshake_unexpected");
        rd_left--;
        if (rd_left == 0) nxt_done = 1;
      end
      if (wr_valid && wr_ready) exp_wdata.push_back(wr_data);
      if (cmd_valid && cmd_ready) begin
        cmd_count++;
        for (int i = 0; i <= int'(cmd_len); i++)
          exp_strobe.push_back({cmd_write, cmd_addr + 32'(i)});
        if (!cmd_write) rd_left = int'(cmd_len) + 1;
      end
      prev_rd_strobe = mem_read;
      prev_wr_strobe = mem_write;
      prev_wr_hs     = wr_valid && wr_ready;
      prev_rd_wait   = rd_valid && !rd_ready;
      prev_rd_data   = rd_data;
      exp_done       = nxt_done;
    end
    if (mem_write) mem[mem_addrs] = mem_data_in;
    if (mem_read) mem_data_out = mem_rd(mem_addrs);
  end

  // Driver tasks all begin and end 1 time unit after a rising edge.
  task automatic issue(input bit w, input logic [31:0] a, input logic [3:0] l);
    bit ok = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) fail_now("cmd_accept_timeout");
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_write = ~w; cmd_addr = ~a; cmd_len = ~l;
  endtask

  task automatic put_word(input logic [31:0] d);
    bit ok = 0;
    wr_valid = 1'b1; wr_data = d;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (wr_ready) begin ok = 1; break; end
    end
    if (!ok) fail_now("wr_accept_timeout");
    @(posedge clk); #1;
    wr_valid = 1'b0; wr_data = 32'h0BAD_0BAD;
  endtask

  task automatic take_word(input int stall);
    bit ok = 0;
    rd_ready = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (rd_valid) begin ok = 1; break; end
    end
    if (!ok) fail_now("rd_valid_timeout");
    repeat (stall) @(negedge clk);
    @(posedge clk); #1 rd_ready = 1'b1;
    @(posedge clk); #1 rd_ready = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    if (!ok) fail_now("done_timeout");
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [31:0] r_addr, r_data;
  int          r_len, r_stall;
  bit          r_w;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_mem_read", 32'(mem_read), 32'd0);
    chk("reset_mem_write", 32'(mem_write), 32'd0);
    chk("reset_mem_addrs", mem_addrs, 32'd0);
    chk("reset_mem_data_in", mem_data_in, 32'd0);
    chk("reset_rd_data", rd_data, 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_wr_ready", 32'(wr_ready), 32'd0);
    @(posedge clk); #1;

    // single-word read
    mem[32'h10] = 32'hDEADBEEF;
    strobe_log.delete();
    rd_ready = 1'b1;
    issue(1'b0, 32'h10, 4'd0);
    wait_done();
    rd_ready = 1'b0;
    chk("t1_rd_data", last_rd, 32'hDEADBEEF);
    chk("t1_strobe_count", 32'(strobe_log.size()), 32'd1);
    chk("t1_strobe_addr", strobe_log[0], 32'h10);

    // four-word write burst
    strobe_log.delete();
    issue(1'b1, 32'h20, 4'd3);
    for (int i = 0; i < 4; i++) put_word(32'hA0 + 32'(i));
    wait_done();
    chk("t2_strobe_count", 32'(strobe_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("t2_mem_word", mem_rd(32'h20 + 32'(i)), 32'hA0 + 32'(i));

    // read with consumer backpressure
    mem[32'h30] = 32'h1111_0030;
    mem[32'h31] = 32'h2222_0031;
    strobe_log.delete();
    issue(1'b0, 32'h30, 4'd1);
    take_word(5);
    chk("t3_word0", last_rd, 32'h1111_0030);
    chk("t3_strobes_mid", 32'(strobe_log.size()), 32'd1);
    take_word(5);
    wait_done();
    chk("t3_word1", last_rd, 32'h2222_0031);
    chk("t3_strobe_count", 32'(strobe_log.size()), 32'd2);

    // address wrap
    mem[32'h0] = 32'h5A5A_5A5A;
    strobe_log.delete();
    issue(1'b1, 32'hFFFF_FFFF, 4'd1);
    put_word(32'hC0);
    put_word(32'hC1);
    wait_done();
    chk("t4_addr0", strobe_log[0], 32'hFFFF_FFFF);
    chk("t4_addr1", strobe_log[1], 32'h0000_0000);
    chk("t4_mem_top", mem_rd(32'hFFFF_FFFF), 32'hC0);
    chk("t4_mem_zero", mem_rd(32'h0), 32'hC1);

    // reset while waiting for the third write word
    for (int i = 0; i < 4; i++) mem[32'h40 + 32'(i)] = 32'h5555_0000 + 32'(i);
    issue(1'b1, 32'h40, 4'd3);
    put_word(32'hB0);
    put_word(32'hB1);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (wr_ready) break;
    end
    chk("t5_in_wr_data", 32'(wr_ready), 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("t5_mem_write", 32'(mem_write), 32'd0);
    chk("t5_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t5_done", 32'(done), 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("t5_no_done", 32'(done), 32'd0);
    end
    chk("t5_word0", mem_rd(32'h40), 32'hB0);
    chk("t5_word1", mem_rd(32'h41), 32'hB1);
    chk("t5_word2", mem_rd(32'h42), 32'h5555_0002);
    chk("t5_word3", mem_rd(32'h43), 32'h5555_0003);
    @(posedge clk); #1;

    // mixed bursts, 16-word maximum included
    for (int b = 0; b < 24; b++) begin
      r_w     = 1'($urandom_range(0, 1));
      r_addr  = (b % 4 == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
      r_len   = (b == 5) ? 15 : int'($urandom_range(0, 5));
      r_stall = int'($urandom_range(0, 2));
      if (r_w) begin
        issue(1'b1, r_addr, 4'(r_len));
        for (int i = 0; i <= r_len; i++) begin
          r_data = $urandom;
          put_word(r_data);
        end
      end else if (r_stall == 0) begin
        rd_ready = 1'b1;
        issue(1'b0, r_addr, 4'(r_len));
      end else begin
        issue(1'b0, r_addr, 4'(r_len));
        for (int i = 0; i <= r_len; i++) take_word(r_stall);
      end
      wait_done();
      rd_ready = 1'b0;
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("done_count_vs_cmds", 32'(done_count), 32'(cmd_count));
    chk("no_pending_strobes", 32'(exp_strobe.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
